// File: rtl/run_length_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : run_length_monitor                                           |
// | Description : Measures runs of 1s on a qualified bit stream, pulses detect |
// |               at MIN_RUN and buffers qualifying run lengths for a consumer.|
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module run_length_monitor #(
  parameter int CNT_W   = 8,
  parameter int MIN_RUN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_en,
  output logic [CNT_W-1:0] out_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             detect,
  output logic             dropped
);

  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_MIN_RUN = CNT_W'(MIN_RUN);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_run_cnt;

  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_emit;
  logic             w_detect_next;
  logic             w_load;

  assign w_cnt_inc = (r_run_cnt == c_CNT_MAX) ? r_run_cnt : r_run_cnt + CNT_W'(1);

  // A run ends on an enabled 0; it only produces a result once it is long enough.
  assign w_emit = din_en && !din && (r_state == ST_RUN) && (r_run_cnt >= c_MIN_RUN);

  // Pulse only on the sample that moves the count onto MIN_RUN, never while parked there.
  assign w_detect_next = din_en && din &&
                         ((r_state == ST_IDLE) ? (MIN_RUN == 1)
                                               : ((r_run_cnt != c_MIN_RUN) && (w_cnt_inc == c_MIN_RUN)));

  assign w_load = w_emit && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_run_cnt <= '0;
      out_len   <= '0;
      out_valid <= 1'b0;
      detect    <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      detect <= w_detect_next;

      if (din_en) begin
        case (r_state)
          ST_IDLE: begin
            if (din) begin
              r_state   <= ST_RUN;
              r_run_cnt <= CNT_W'(1);
            end else begin
              r_run_cnt <= '0;
            end
          end
          ST_RUN: begin
            if (din) begin
              r_run_cnt <= w_cnt_inc;
            end else begin
              r_state   <= ST_IDLE;
              r_run_cnt <= '0;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_run_cnt <= '0;
          end
        endcase
      end

      if (w_load) begin
        out_len   <= r_run_cnt;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (w_emit && out_valid && !out_ready) begin
        dropped <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_run_length_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_run_length_monitor                                        |
// | Description : Randomized scoreboard bench for run_length_monitor.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_run_length_monitor;

  localparam int CNT_W   = 4;
  localparam int MIN_RUN = 4;
  localparam int MAX_LEN = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             din = 1'b0;
  logic             din_en = 1'b0;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] out_len;
  logic             out_valid;
  logic             detect;
  logic             dropped;

  int checks = 0;
  int failures = 0;

  // reference model state
  int run_len = 0;
  bit m_full = 1'b0;
  bit m_detect = 1'b0;
  bit m_dropped = 1'b0;
  int exp_q[$];

  run_length_monitor #(.CNT_W(CNT_W), .MIN_RUN(MIN_RUN)) dut (
    .clk(clk), .reset(reset), .din(din), .din_en(din_en),
    .out_len(out_len), .out_valid(out_valid), .out_ready(out_ready),
    .detect(detect), .dropped(dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at t=%0t", name, actual, expected, $time);
    end
  endtask

  // Model: a run is just a count of consecutive enabled 1s; the buffer is one slot.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        run_len = 0; m_full = 0; m_detect = 0; m_dropped = 0;
        exp_q.delete();
      end else begin
        bit consumed;
        bit emit;
        int len;
        consumed = m_full && out_ready;
        emit = 0;
        len = 0;
        m_detect = 0;
        if (din_en) begin
          if (din) begin
            run_len++;
            m_detect = (run_len == MIN_RUN);
          end else begin
            if (run_len >= MIN_RUN) begin
              emit = 1;
              len = (run_len > MAX_LEN) ? MAX_LEN : run_len;
            end
            run_len = 0;
          end
        end
        if (emit && (!m_full || out_ready)) begin
          exp_q.push_back(len);
          m_full = 1;
        end else begin
          if (emit) m_dropped = 1;
          if (consumed) m_full = 0;
        end
      end
    end
  end

  // Monitor: mid-cycle, compare flags and pop the scoreboard on each handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("out_valid", out_valid, m_full);
        check("detect", detect, m_detect);
        check("dropped", dropped, m_dropped);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
          end else begin
            int e;
            e = exp_q.pop_front();
            check("out_len", out_len, e);
          end
        end
      end
    end
  end

  task automatic drive(input bit d, input bit en, input bit rdy);
    @(posedge clk);
    #2;
    din = d; din_en = en; out_ready = rdy;
  endtask

  task automatic run_ones(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b1, rdy);
    drive(1'b0, 1'b1, rdy);
  endtask

  task automatic async_reset_check();
    @(posedge clk);
    #4;
    reset = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_len", out_len, 0);
    check("rst_detect", detect, 0);
    check("rst_dropped", dropped, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    #1;
    check("init_out_valid", out_valid, 0);
    check("init_out_len", out_len, 0);
    check("init_detect", detect, 0);
    check("init_dropped", dropped, 0);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;

    run_ones(6, 1'b1);                 // out_len=6
    drive(1'b0, 1'b1, 1'b1);
    run_ones(3, 1'b1);                 // discarded
    repeat (3) drive(1'b0, 1'b1, 1'b1);
    run_ones(5, 1'b0);                 // buffered
    run_ones(7, 1'b0);                 // dropped
    repeat (3) drive(1'b0, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 1'b1, 1'b1);
    run_ones(20, 1'b1);                // saturates at 15
    drive(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin  // alternate enable
      drive(1'b1, 1'b1, 1'b1);
      drive(1'b1, 1'b0, 1'b1);
    end
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);

    run_ones(5, 1'b0);                 // leave out_valid pending
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
    async_reset_check();
    run_ones(4, 1'b1);
    repeat (3) drive(1'b0, 1'b1, 1'b1);

    for (int blk = 0; blk < 4; blk++) begin
      for (int i = 0; i < 800; i++) begin
        drive($urandom_range(0, 9) < 7, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      end
      async_reset_check();
    end

    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 9) < 8, 1'b1, ($urandom_range(0, 1) != 0));
    end
    repeat (5) drive(1'b0, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/run_length_monitor.md
RUN_LENGTH_MONITOR -- requirements
Module: run_length_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 8, run-length counter and output width in bits.
REQ-002 SHALL have parameter MIN_RUN, default 4, minimum qualifying run length; legal range 1 to 2^CNT_W-1.
REQ-003 SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-004 SHALL have port reset, input, 1 bit; reset is asynchronous, active-high; clock is clk.
REQ-005 SHALL have port din, input, 1 bit, registered AND-stage result; the stream under test.
REQ-006 SHALL have port din_en, input, 1 bit, sample qualifier; din is sampled only when din_en=1.
REQ-007 SHALL have port out_len, output, CNT_W bits, length of the completed qualifying run.
REQ-008 SHALL have port out_valid, output, 1 bit, out_len holds an unconsumed result.
REQ-009 SHALL have port out_ready, input, 1 bit, consumer accepts out_len.
REQ-010 SHALL have port detect, output, 1 bit, one-cycle pulse when the current run reaches MIN_RUN.
REQ-011 SHALL have port dropped, output, 1 bit, sticky flag: a qualifying result was lost.

Function
REQ-012 SHALL implement a two-state FSM: IDLE (no run open) and RUN (run open, run_cnt >= 1).
REQ-013 SHALL hold the state and run_cnt unchanged in any cycle with din_en=0.
REQ-014 SHALL, in IDLE with din_en=1 and din=1, enter RUN with run_cnt=1.
REQ-015 SHALL, in IDLE with din_en=1 and din=0, remain in IDLE with run_cnt=0.
REQ-016 SHALL, in RUN with din_en=1 and din=1, increment run_cnt, saturating at 2^CNT_W-1 with no wrap-around.
REQ-017 SHALL, in RUN with din_en=1 and din=0, end the run, return to IDLE, and clear run_cnt to 0.
REQ-018 SHALL emit the final run_cnt as a result when a run ends with run_cnt >= MIN_RUN.
REQ-019 SHALL discard a run that ends with run_cnt < MIN_RUN, without affecting out_valid or dropped.
REQ-020 SHALL assert detect for exactly one cycle, registered, in the cycle after the sample that makes run_cnt equal MIN_RUN; at most one pulse per run.
REQ-021 SHALL, when MIN_RUN=1, pulse detect in the cycle after the first 1 sample.
REQ-022 SHALL present an emitted result as out_len with out_valid=1 in the cycle after the run-ending sample (latency 1).
REQ-023 SHALL provide a single-entry output buffer; out_valid and out_len stay stable until a cycle where out_valid=1 and out_ready=1.
REQ-024 SHALL clear out_valid after the handshake cycle unless a new result loads in the same cycle.
REQ-025 SHALL load a new result when the buffer is empty, or when it is being consumed in the same cycle (out_valid=1 and out_ready=1); dropped is not set in that case.
REQ-026 SHALL, when a result is emitted while out_valid=1 and out_ready=0, discard the new result, keep the buffered out_len, and set dropped=1.
REQ-027 SHALL keep dropped set until reset.
REQ-028 SHALL ignore out_ready while out_valid=0.

Reset
REQ-029 SHALL, on reset assertion, immediately force the FSM to IDLE and clear run_cnt, out_len, out_valid, detect, and dropped to 0, independent of clk.
REQ-030 SHALL discard any open run on reset; the first din=1 sample after reset release starts a new run at run_cnt=1.

Verification
REQ-031 CNT_W=8, MIN_RUN=4, din_en=1, out_ready=1, din=1 for 6 samples then 0 -> detect pulses once, in the cycle after the 4th 1; out_valid=1 with out_len=6 for one cycle, in the cycle after the 0.
REQ-032 Run of 3 ones then a 0 -> detect stays 0, out_valid stays 0, dropped stays 0.
REQ-033 out_ready=0, qualifying runs of 5 then 7 -> out_len=5 held with out_valid=1, dropped=1; then out_ready=1 -> a single handshake of 5.
REQ-034 CNT_W=4, MIN_RUN=4, 20 consecutive ones then a 0 -> out_len=15.
REQ-035 din=1 held with din_en high on alternate cycles (5 enabled samples), then din=0 with din_en=1 -> out_len=5; detect asserted after the 4th enabled sample.
REQ-036 Reset asserted mid-run (run_cnt=3) and mid out_valid -> all outputs 0 asynchronously; a run of 4 after release -> out_len=4.
